// File: rtl/console_pkg.sv
// Shared constants and state encoding for the text console controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package console_pkg;

  // Control codes and the printable range
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BLANK = 8'h20;
  localparam logic [7:0] CH_MIN   = 8'h20;
  localparam logic [7:0] CH_MAX   = 8'h7E;

  // FSM state encoding
  localparam logic [1:0] ENC_IDLE        = 2'd0;
  localparam logic [1:0] ENC_CLEAR       = 2'd1;
  localparam logic [1:0] ENC_SCROLL_COPY = 2'd2;
  localparam logic [1:0] ENC_SCROLL_FILL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE        = ENC_IDLE,
    ST_CLEAR       = ENC_CLEAR,
    ST_SCROLL_COPY = ENC_SCROLL_COPY,
    ST_SCROLL_FILL = ENC_SCROLL_FILL
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_MIN) && (c <= CH_MAX);
  endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor position register with command-driven update and scroll detection.
// Latency: position updates on the clock edge after a command; o_nxt_* and o_wrap_out are combinational.
// Backpressure: none; at most one command is asserted per cycle by the controller.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset (cursor -> (0,0))
//   i_advance           printable char written: move one cell right, wrapping rows
//   i_newline           col=0, next row (stays on last row and flags a scroll)
//   i_cr                col=0
//   i_backspace         move one cell left, wrapping to previous row; sticks at (0,0)
//   i_home              cursor -> (0,0)
//   o_row, o_col        current cursor
//   o_nxt_row, o_nxt_col  cursor after this cycle's command
//   o_wrap_out          this cycle's command ran off the bottom row; a scroll is needed
module console_cursor #(
  parameter int COLS = 16,
  parameter int ROWS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_advance,
  input  logic                      i_newline,
  input  logic                      i_cr,
  input  logic                      i_backspace,
  input  logic                      i_home,
  output logic [$clog2(ROWS)-1:0]   o_row,
  output logic [$clog2(COLS)-1:0]   o_col,
  output logic [$clog2(ROWS)-1:0]   o_nxt_row,
  output logic [$clog2(COLS)-1:0]   o_nxt_col,
  output logic                      o_wrap_out
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [RW-1:0] w_row_nxt;
  logic [CW-1:0] w_col_nxt;
  logic          w_wrap;

  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    w_wrap    = 1'b0;
    if (i_home) begin
      w_row_nxt = '0;
      w_col_nxt = '0;
    end else if (i_advance) begin
      if (r_col == COL_LAST) begin
        w_col_nxt = '0;
        // On the bottom row the row index holds; the scroll moves the text instead
        if (r_row == ROW_LAST) w_wrap = 1'b1;
        else                   w_row_nxt = r_row + RW'(1);
      end else begin
        w_col_nxt = r_col + CW'(1);
      end
    end else if (i_newline) begin
      w_col_nxt = '0;
      if (r_row == ROW_LAST) w_wrap = 1'b1;
      else                   w_row_nxt = r_row + RW'(1);
    end else if (i_cr) begin
      w_col_nxt = '0;
    end else if (i_backspace) begin
      if (r_col != '0) begin
        w_col_nxt = r_col - CW'(1);
      end else if (r_row != '0) begin
        w_row_nxt = r_row - RW'(1);
        w_col_nxt = COL_LAST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      r_row <= w_row_nxt;
      r_col <= w_col_nxt;
    end
  end

  assign o_row      = r_row;
  assign o_col      = r_col;
  assign o_nxt_row  = w_row_nxt;
  assign o_nxt_col  = w_col_nxt;
  assign o_wrap_out = w_wrap;

endmodule

// File: rtl/text_console_ctrl.sv
// Byte-stream text console: interprets chars/control codes into a ROWSxCOLS cell buffer, scrolls and clears.
// Latency: one byte per cycle in IDLE; scroll and clear each block input for 64 cycles; rd_data is 1 cycle after rd_addr.
// Backpressure: in_ready low outside IDLE and while a clear is requested or pending.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset (restarts with a full clear)
//   in_valid/in_data/in_ready  byte stream handshake
//   clear_req                single-cycle full clear request, remembered if busy
//   rd_addr/rd_data          independent registered read port, {row,col} addressing
//   cursor_row/cursor_col    current cursor
//   busy                     FSM not in IDLE
module text_console_ctrl
  import console_pkg::*;
#(
  parameter int         COLS  = 16,
  parameter int         ROWS  = 4,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [7:0]                     in_data,
  output logic                           in_ready,
  input  logic                           clear_req,
  input  logic [$clog2(ROWS*COLS)-1:0]   rd_addr,
  output logic [7:0]                     rd_data,
  output logic [$clog2(ROWS)-1:0]        cursor_row,
  output logic [$clog2(COLS)-1:0]        cursor_col,
  output logic                           busy
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int AW    = CW + RW;
  localparam int CELLS = ROWS * COLS;
  localparam logic [AW-1:0] CELL_LAST = AW'(CELLS - 1);
  localparam logic [AW-1:0] COPY_LAST = AW'(CELLS - COLS - 1);
  localparam logic [AW-1:0] ROW_STEP  = AW'(COLS);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          r_clear_pending;
  logic [7:0]    r_buf [CELLS];

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_wdata;

  logic          w_acc;
  logic          w_print;
  logic          w_nl;
  logic          w_cr;
  logic          w_bs;
  logic          w_ff;
  logic          w_home;
  logic          w_wrap;
  logic [RW-1:0] w_nxt_row;
  logic [CW-1:0] w_nxt_col;

  assign in_ready = (r_state == ST_IDLE) && !clear_req && !r_clear_pending;
  assign busy     = (r_state != ST_IDLE);

  // Command decode depends only on inputs and registers, so the cursor's
  // combinational wrap flag can feed next-state logic without a loop.
  assign w_acc   = in_valid && in_ready;
  assign w_print = w_acc && is_printable(in_data);
  assign w_nl    = w_acc && (in_data == CH_LF);
  assign w_cr    = w_acc && (in_data == CH_CR);
  assign w_bs    = w_acc && (in_data == CH_BS);
  assign w_ff    = w_acc && (in_data == CH_FF);
  assign w_home  = (r_state == ST_CLEAR) && (r_cnt == CELL_LAST);

  console_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk         (clk),
    .rst         (rst),
    .i_advance   (w_print),
    .i_newline   (w_nl),
    .i_cr        (w_cr),
    .i_backspace (w_bs),
    .i_home      (w_home),
    .o_row       (cursor_row),
    .o_col       (cursor_col),
    .o_nxt_row   (w_nxt_row),
    .o_nxt_col   (w_nxt_col),
    .o_wrap_out  (w_wrap)
  );

  // Next state and the single buffer write port. r_cnt is 0 whenever IDLE is
  // entered (every sequence ends on the last cell and wraps), so it can serve
  // as the cell index for clear, copy and fill alike.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    w_waddr     = r_cnt;
    w_wdata     = BLANK;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (clear_req || r_clear_pending || w_ff) begin
          w_state_nxt = ST_CLEAR;
        end else if (w_wrap) begin
          w_state_nxt = ST_SCROLL_COPY;
        end
        if (w_print) begin
          w_we    = 1'b1;
          w_waddr = {cursor_row, cursor_col};
          w_wdata = in_data;
        end else if (w_bs) begin
          // Blank lands at the post-move position, including a stuck (0,0)
          w_we    = 1'b1;
          w_waddr = {w_nxt_row, w_nxt_col};
        end
      end
      ST_CLEAR: begin
        w_we      = 1'b1;
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == CELL_LAST) w_state_nxt = ST_IDLE;
      end
      ST_SCROLL_COPY: begin
        w_we      = 1'b1;
        w_wdata   = r_buf[r_cnt + ROW_STEP];
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == COPY_LAST) w_state_nxt = ST_SCROLL_FILL;
      end
      ST_SCROLL_FILL: begin
        w_we      = 1'b1;
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == CELL_LAST) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= ST_CLEAR;
      r_cnt           <= '0;
      r_clear_pending <= 1'b0;
      rd_data         <= BLANK;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      rd_data <= r_buf[rd_addr];
      // The pending flag is consumed on the IDLE cycle that launches the clear,
      // so a request landing during any clear still queues one more full clear.
      if (clear_req && (r_state != ST_IDLE)) r_clear_pending <= 1'b1;
      else if (r_state == ST_IDLE)           r_clear_pending <= 1'b0;
    end
  end

  // Storage is deliberately not reset; the post-reset CLEAR blanks it.
  always_ff @(posedge clk) begin
    if (w_we) r_buf[w_waddr] <= w_wdata;
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
module tb_text_console_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       clear_req = 1'b0;
  logic [5:0] rd_addr = 6'd0;
  logic [7:0] rd_data;
  logic [1:0] cursor_row;
  logic [3:0] cursor_col;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  text_console_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .clear_req  (clear_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    wait_ready(n);
    if (n >= 400) begin
      tests_run++;
      tests_failed++;
      $error("FAIL send_timeout: in_ready stayed 0, byte 0x%0h", b);
    end
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] b, input int count);
    for (int i = 0; i < count; i++) send(b);
  endtask

  task automatic read_cell(input int a, output logic [7:0] d);
    rd_addr = 6'(a);
    tick();
    d = rd_data;
  endtask

  task automatic check_cell(input string tag, input int a, input logic [7:0] exp);
    logic [7:0] d;
    read_cell(a, d);
    check(tag, 32'(d), 32'(exp));
  endtask

  task automatic check_region(input string tag, input int lo, input int hi, input logic [7:0] exp);
    int bad;
    logic [7:0] d;
    bad = 0;
    for (int a = lo; a <= hi; a++) begin
      read_cell(a, d);
      if (d !== exp) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic check_cursor(input string tag, input logic [1:0] row, input logic [3:0] col);
    check({tag, "_row"}, 32'(cursor_row), 32'(row));
    check({tag, "_col"}, 32'(cursor_col), 32'(col));
  endtask

  initial begin
    int n;

    // Reset held: input blocked, busy, read port blank, cursor home
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rd_data", 32'(rd_data), 32'h20);
    check_cursor("rst_cursor", 2'd0, 4'd0);

    // 64 clear edges after release; ready in the 65th cycle
    rst = 1'b1;
    wait_ready(n);
    check("clear_edges_to_ready", 32'(n), 32'd64);
    repeat (6) tick();
    check_region("init_all_blank", 0, 63, 8'h20);
    check_cursor("init_cursor", 2'd0, 4'd0);

    // "AB", backspace, "C"
    send(8'h41); send(8'h42); send(8'h08); send(8'h43);
    check_cell("ab_bs_c_cell0", 0, 8'h41);
    check_cell("ab_bs_c_cell1", 1, 8'h43);
    check_cell("ab_bs_c_cell2", 2, 8'h20);
    check_cursor("ab_bs_c_cursor", 2'd0, 4'd2);

    // CR then backspace at (0,0): cursor sticks, cell 0 still blanked
    send(8'h0D); send(8'h08);
    check_cursor("bs_home_cursor", 2'd0, 4'd0);
    check_cell("bs_home_cell0", 0, 8'h20);
    check_cell("bs_home_cell1", 1, 8'h43);

    // Form feed, pre-fill rows a/b/c and part of d, then 16 'X' on the bottom row
    send(8'h0C);
    send_n(8'h61, 16); send_n(8'h62, 16); send_n(8'h63, 16); send_n(8'h64, 5);
    send(8'h0D);
    check_cursor("prefill_cursor", 2'd3, 4'd0);
    send_n(8'h58, 15);
    check_cursor("x15_cursor", 2'd3, 4'd15);
    send(8'h58);
    check("scroll_start_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check("scroll_busy_cycles", 32'(n), 32'd64);
    check_region("scroll_row0_b", 0, 15, 8'h62);
    check_region("scroll_row1_c", 16, 31, 8'h63);
    check_region("scroll_row2_x", 32, 47, 8'h58);
    check_region("scroll_row3_blank", 48, 63, 8'h20);
    check_cursor("scroll_cursor", 2'd3, 4'd0);

    // Newline on the bottom row scrolls again
    send(8'h0A);
    wait_ready(n);
    check("lf_scroll_edges", 32'(n), 32'd64);
    check_cell("lf_scroll_cell0", 0, 8'h63);
    check_cell("lf_scroll_cell16", 16, 8'h58);
    check_cell("lf_scroll_cell32", 32, 8'h20);
    check_cursor("lf_scroll_cursor", 2'd3, 4'd0);

    // Newlines from home, then backspace across a row boundary
    send(8'h0C);
    send_n(8'h0A, 3);
    check_cursor("lf3_cursor", 2'd3, 4'd0);
    send(8'h08);
    check_cursor("bs_wrap_cursor", 2'd2, 4'd15);

    // clear_req in the same cycle as a valid 'Q'
    wait_ready(n);
    in_valid  = 1'b1;
    in_data   = 8'h51;
    clear_req = 1'b1;
    #1;
    check("clrq_in_ready", 32'(in_ready), 32'd0);
    tick();
    clear_req = 1'b0;
    check("clrq_busy", 32'(busy), 32'd1);
    wait_ready(n);
    check("clrq_clear_edges", 32'(n), 32'd64);
    tick();
    in_valid = 1'b0;
    check_cell("clrq_q_cell0", 0, 8'h51);
    check_cursor("clrq_cursor", 2'd0, 4'd1);

    // clear_req pulse mid-scroll: scroll, one IDLE cycle, then full clear
    send_n(8'h0A, 3);
    send(8'h52);
    send(8'h0A);
    n = 0;
    while (!in_ready && n < 400) begin
      tick();
      n++;
      clear_req = (n == 10);
    end
    clear_req = 1'b0;
    check("scroll_then_clear_edges", 32'(n), 32'd129);
    check_region("scroll_clear_blank", 0, 63, 8'h20);
    check_cursor("scroll_clear_cursor", 2'd0, 4'd0);

    // One-cycle reset mid-scroll restarts with a clear
    send(8'h4D);
    send_n(8'h0A, 3);
    send(8'h4E);
    send(8'h0A);
    repeat (5) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_busy", 32'(busy), 32'd1);
    wait_ready(n);
    check("midrst_clear_edges", 32'(n), 32'd64);
    check_region("midrst_blank", 0, 63, 8'h20);
    check_cursor("midrst_cursor", 2'd0, 4'd0);

    // Non-printables 0x01 and 0x7F are consumed with no effect; 0x7E is printable
    send(8'h4B);
    send(8'h01);
    send(8'h7F);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_in_ready", 32'(in_ready), 32'd1);
    check_cursor("drop_cursor", 2'd0, 4'd1);
    check_cell("drop_cell0", 0, 8'h4B);
    check_cell("drop_cell1", 1, 8'h20);
    send(8'h7E);
    check_cell("tilde_cell1", 1, 8'h7E);
    check_cursor("tilde_cursor", 2'd0, 4'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
